j1_irq_ctrl: RTL

//  Memory-mapped interrupt controller on the J1 I/O bus; drives the core's int_req input.
//  Per line: synchronises async requests, detects rising edges, latches them as pending, masks them.

---
 rtl/j1_irq_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/j1_irq_ctrl.sv
// j1_irq_ctrl: memory-mapped interrupt controller on the J1 I/O bus.
//   Each line is synchronised, rising-edge detected, latched as pending and
//   masked; the lowest-numbered active line is offered to the core through a
//   request / claim / end-of-interrupt handshake (one interrupt in service,
//   no nesting).
// Ports:
//   sys_clk_i    system clock (shared with the J1 core)
//   sys_rst_n_i  asynchronous active-low reset
//   irq_i        raw asynchronous interrupt lines, active high
//   io_rd/io_wr  J1 I/O read / write strobes (io_wr also fires for RAM writes)
//   io_addr      J1 I/O byte address
//   io_dout      J1 write data
//   io_din       read data, combinational from io_addr, 0 when not addressed
//   int_req      interrupt request to the core
//   in_service   high while a claimed interrupt has not been ended
// Register map (byte offsets from BASE_ADDR):
//   +0 CTRL (bit0 GIE)  +2 ENABLE  +4 PENDING (W1C)  +6 CLAIM (R)  +8 EOI (W)
module j1_irq_ctrl #(
  parameter int unsigned N_IRQ     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h7F00
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_n_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      io_addr,
  input  logic [15:0]      io_dout,
  output logic [15:0]      io_din,
  output logic             int_req,
  output logic             in_service
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  localparam logic [15:0] A_CTRL  = BASE_ADDR;
  localparam logic [15:0] A_EN    = BASE_ADDR + 16'd2;
  localparam logic [15:0] A_PEND  = BASE_ADDR + 16'd4;
  localparam logic [15:0] A_CLAIM = BASE_ADDR + 16'd6;
  localparam logic [15:0] A_EOI   = BASE_ADDR + 16'd8;

  state_t           r_state, w_state_nxt;
  logic [N_IRQ-1:0] r_sync1, r_sync2, r_prev;
  logic             r_gie;
  logic [N_IRQ-1:0] r_enable;
  logic [N_IRQ-1:0] r_pending;
  logic [3:0]       r_isr_id;

  logic [N_IRQ-1:0] w_edge, w_active, w_w1c, w_claim_mask, w_pending_nxt;
  logic [3:0]       w_winner;
  logic             w_any, w_found;
  logic             w_hit_ctrl, w_hit_en, w_hit_pend, w_hit_claim, w_hit_eoi;
  logic             w_claim_take, w_eoi;
  logic             w_unused;

  assign w_hit_ctrl  = (io_addr == A_CTRL);
  assign w_hit_en    = (io_addr == A_EN);
  assign w_hit_pend  = (io_addr == A_PEND);
  assign w_hit_claim = (io_addr == A_CLAIM);
  assign w_hit_eoi   = (io_addr == A_EOI);

  // Only the low data bits are architected; the rest are don't-care.
  assign w_unused = ^io_dout;

  // Synchroniser and edge flops reset high: a line that is already high when
  // reset releases must first be seen low before a rise can be recognised.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge   = r_sync2 & ~r_prev;
  assign w_active = r_pending & r_enable & {N_IRQ{r_gie}};
  assign w_any    = |w_active;

  // Priority encoder: lowest set index wins; also builds the claim clear mask.
  always_comb begin
    w_winner     = '0;
    w_found      = 1'b0;
    w_claim_mask = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (w_active[i] && !w_found) begin
        w_winner = 4'(i);
        w_found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      w_claim_mask[i] = w_claim_take && (4'(i) == w_winner);
    end
  end

  assign w_claim_take = io_rd && w_hit_claim && (r_state == S_REQ) && w_any;
  assign w_eoi        = io_wr && w_hit_eoi && (r_state == S_SVC) &&
                        (io_dout[3:0] == r_isr_id);
  assign w_w1c        = (io_wr && w_hit_pend) ? io_dout[N_IRQ-1:0] : '0;

  // A new edge overrides a same-cycle clear (W1C or claim).
  assign w_pending_nxt = (r_pending & ~w_w1c & ~w_claim_mask) | w_edge;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_gie     <= 1'b0;
      r_enable  <= '0;
      r_pending <= '0;
      r_isr_id  <= '0;
    end else begin
      if (io_wr && w_hit_ctrl) r_gie    <= io_dout[0];
      if (io_wr && w_hit_en)   r_enable <= io_dout[N_IRQ-1:0];
      r_pending <= w_pending_nxt;
      if (w_claim_take)        r_isr_id <= w_winner;
    end
  end

  // FSM: state register
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_claim_take) w_state_nxt = S_SVC;
        else if (!w_any)  w_state_nxt = S_IDLE;
      end
      S_SVC:   if (w_eoi) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    int_req    = (r_state == S_REQ);
    in_service = (r_state == S_SVC);
  end

  // Read mux; CLAIM shows the winner only when a claim would succeed.
  always_comb begin
    io_din = '0;
    if (w_hit_ctrl) begin
      io_din[0] = r_gie;
    end else if (w_hit_en) begin
      io_din[N_IRQ-1:0] = r_enable;
    end else if (w_hit_pend) begin
      io_din[N_IRQ-1:0] = r_pending;
    end else if (w_hit_claim) begin
      if ((r_state == S_REQ) && w_any) io_din[3:0] = w_winner;
      else                             io_din = '1;
    end
  end

endmodule
